hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the front end. It sits beside the decode stage and issue point. It keeps a register scoreboard of in-flight destination writes and stalls issue on RAW or WAW hazards, and on data-cache busy. It also holds issue while a branch is unresolved and drives a timed flush of ifetch/decode on a taken branch. A saturating stall-cycle performance counter is included.

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 59 +++++
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the front-end hazard controller.
//   rvga_reg             : architectural register index
//   reg_mask_t           : one bit per architectural register
//   hazard_ctrl_state_e  : sequencing FSM states
//   reg_onehot()         : register index to one-hot mask
package hazard_ctrl_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [REG_W-1:0]    rvga_reg;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    typedef enum logic [1:0] {
        e_hc_run     = 2'd0,
        e_hc_br_wait = 2'd1,
        e_hc_flush   = 2'd2
    } hazard_ctrl_state_e;

    function automatic reg_mask_t reg_onehot(input rvga_reg r);
        return reg_mask_t'(1) << r;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode / writeback / branch bundle between the pipeline and hazard_ctrl.
//   master : pipeline side, drives decode, writeback and branch info
//   slave  : controller side, returns issue/stall/flush and stall_cnt
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic             dec_v;
    rvga_reg          dec_rs1;
    rvga_reg          dec_rs2;
    logic             dec_rs1_used;
    logic             dec_rs2_used;
    rvga_reg          dec_rd;
    logic             dec_rd_w_v;
    logic             dec_br_v;
    logic             dcache_busy;
    logic             wb_v;
    rvga_reg          wb_rd;
    logic             br_resolve_v;
    logic             br_taken;
    logic             issue;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output dec_v, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
               dec_rd, dec_rd_w_v, dec_br_v, dcache_busy,
               wb_v, wb_rd, br_resolve_v, br_taken,
        input  issue, stall, flush, stall_cnt
    );

    modport slave (
        input  dec_v, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
               dec_rd, dec_rd_w_v, dec_br_v, dcache_busy,
               wb_v, wb_rd, br_resolve_v, br_taken,
        output issue, stall, flush, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: tracks in-flight destination writes and flags
// RAW/WAW hazards for the instruction sitting in decode.
//   clk, rst                  : clock, async active-high reset
//   issue                     : decode instruction advances this cycle
//   dec_rs1/rs2(_used)        : source registers and their use flags
//   dec_rd, dec_rd_w_v        : destination register and write flag
//   wb_v, wb_rd               : writeback retiring a register write
//   hazard                    : decode instruction must not issue
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    issue,
    input  rvga_reg dec_rs1,
    input  logic    dec_rs1_used,
    input  rvga_reg dec_rs2,
    input  logic    dec_rs2_used,
    input  rvga_reg dec_rd,
    input  logic    dec_rd_w_v,
    input  logic    wb_v,
    input  rvga_reg wb_rd,
    output logic    hazard
);

    reg_mask_t pending;
    reg_mask_t wb_mask;
    reg_mask_t eff;
    reg_mask_t pending_nxt;
    logic      rd_nonzero;

    assign rd_nonzero = (dec_rd != '0);

    // Write-through register file: a same-cycle writeback already resolves.
    assign wb_mask = wb_v ? reg_onehot(wb_rd) : '0;
    assign eff     = pending & ~wb_mask;

    assign hazard = (dec_rs1_used & eff[dec_rs1])
                  | (dec_rs2_used & eff[dec_rs2])
                  | (dec_rd_w_v & rd_nonzero & eff[dec_rd]);

    // Clear on writeback first so a same-cycle issue of the same rd wins.
    always_comb begin
        pending_nxt = pending & ~wb_mask;
        if (issue && dec_rd_w_v && rd_nonzero) begin
            pending_nxt = pending_nxt | reg_onehot(dec_rd);
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Front-end sequencing controller: stalls issue on register hazards and
// dcache busy, holds issue across an unresolved branch and flushes
// ifetch/decode for FLUSH_CYCLES cycles after a taken branch.
//   clk, rst : clock, async active-high reset
//   bus      : hazard_ctrl_if slave (decode, writeback, branch inputs;
//              issue/stall combinational, flush/stall_cnt registered)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
)(
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

    hazard_ctrl_state_e state;
    logic [FC_W-1:0]    flush_cnt;
    logic               flush;
    logic [CNT_W-1:0]   stall_cnt;
    logic               hazard;
    logic               issue_c;
    logic               stall_c;

    hazard_scoreboard u_sb (
        .clk          (clk),
        .rst          (rst),
        .issue        (issue_c),
        .dec_rs1      (bus.dec_rs1),
        .dec_rs1_used (bus.dec_rs1_used),
        .dec_rs2      (bus.dec_rs2),
        .dec_rs2_used (bus.dec_rs2_used),
        .dec_rd       (bus.dec_rd),
        .dec_rd_w_v   (bus.dec_rd_w_v),
        .wb_v         (bus.wb_v),
        .wb_rd        (bus.wb_rd),
        .hazard       (hazard)
    );

    // Issue/stall decision, zero-cycle from decode inputs.
    always_comb begin
        issue_c = 1'b0;
        stall_c = 1'b0;
        case (state)
            e_hc_run: begin
                issue_c = bus.dec_v & ~hazard & ~bus.dcache_busy & ~flush;
                stall_c = bus.dec_v & ~issue_c;
            end
            e_hc_br_wait: begin
                stall_c = bus.dec_v;
            end
            default: begin
                // Flushing: let ifetch/decode refill.
            end
        endcase
    end

    // Sequencing FSM with registered flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= e_hc_run;
            flush     <= 1'b0;
            flush_cnt <= '0;
        end else begin
            case (state)
                e_hc_run: begin
                    if (issue_c && bus.dec_br_v) begin
                        state <= e_hc_br_wait;
                    end
                end
                e_hc_br_wait: begin
                    if (bus.br_resolve_v) begin
                        if (bus.br_taken) begin
                            state     <= e_hc_flush;
                            flush     <= 1'b1;
                            flush_cnt <= FC_W'(FLUSH_CYCLES);
                        end else begin
                            state <= e_hc_run;
                        end
                    end
                end
                e_hc_flush: begin
                    if (flush_cnt <= FC_W'(1)) begin
                        state     <= e_hc_run;
                        flush     <= 1'b0;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                    end
                end
                default: begin
                    state     <= e_hc_run;
                    flush     <= 1'b0;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_c && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.issue     = issue_c;
    assign bus.stall     = stall_c;
    assign bus.flush     = flush;
    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    hazard_ctrl_if #(.CNT_W(32)) bus ();

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.dec_v        = 1'b0;
        bus.dec_rs1      = '0;
        bus.dec_rs2      = '0;
        bus.dec_rs1_used = 1'b0;
        bus.dec_rs2_used = 1'b0;
        bus.dec_rd       = '0;
        bus.dec_rd_w_v   = 1'b0;
        bus.dec_br_v     = 1'b0;
        bus.dcache_busy  = 1'b0;
        bus.wb_v         = 1'b0;
        bus.wb_rd        = '0;
        bus.br_resolve_v = 1'b0;
        bus.br_taken     = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs sampled 1 ns later.
    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #12;
        n_chk++; if (bus.issue !== 1'b0) begin n_fail++; $display("FAIL reset_issue: got %b want 0", bus.issue); end
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
        n_chk++; if (bus.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt); end
        n_chk++; if (dut.u_sb.pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", dut.u_sb.pending); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_raw();
        step();
        bus.dec_v = 1'b1; bus.dec_rd = 5'd5; bus.dec_rd_w_v = 1'b1;
        #1;
        n_chk++; if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL raw_first_issue: got %b want 1", bus.issue); end
        step();
        bus.dec_v = 1'b1; bus.dec_rs1 = 5'd5; bus.dec_rs1_used = 1'b1;
        bus.dec_rd = 5'd6; bus.dec_rd_w_v = 1'b1;
        #1;
        n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", bus.stall); end
        n_chk++; if (bus.issue !== 1'b0) begin n_fail++; $display("FAIL raw_hold: got %b want 0", bus.issue); end
        step();
        bus.dec_v = 1'b1; bus.dec_rs1 = 5'd5; bus.dec_rs1_used = 1'b1;
        bus.dec_rd = 5'd6; bus.dec_rd_w_v = 1'b1;
        #1;
        n_chk++; if (bus.stall_cnt !== 32'd1) begin n_fail++; $display("FAIL raw_cnt1: got %0d want 1", bus.stall_cnt); end
        step();
        bus.dec_v = 1'b1; bus.dec_rs1 = 5'd5; bus.dec_rs1_used = 1'b1;
        bus.dec_rd = 5'd6; bus.dec_rd_w_v = 1'b1;
        bus.wb_v = 1'b1; bus.wb_rd = 5'd5;
        #1;
        n_chk++; if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL raw_wb_issue: got %b want 1", bus.issue); end
        n_chk++; if (bus.stall_cnt !== 32'd2) begin n_fail++; $display("FAIL raw_cnt2: got %0d want 2", bus.stall_cnt); end
        step();
        #1;
        n_chk++; if (dut.u_sb.pending !== 32'h0000_0040) begin n_fail++; $display("FAIL raw_pending: got %h want 00000040", dut.u_sb.pending); end
        step();
        bus.wb_v = 1'b1; bus.wb_rd = 5'd6;
        step();
        #1;
        n_chk++; if (dut.u_sb.pending !== 32'h0) begin n_fail++; $display("FAIL raw_drain: got %h want 0", dut.u_sb.pending); end
    endtask

    task automatic test_x0();
        step();
        bus.dec_v = 1'b1; bus.dec_rd = 5'd0; bus.dec_rd_w_v = 1'b1;
        #1;
        n_chk++; if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL x0_issue_wr: got %b want 1", bus.issue); end
        step();
        bus.dec_v = 1'b1; bus.dec_rs1 = 5'd0; bus.dec_rs1_used = 1'b1;
        bus.dec_rs2 = 5'd0; bus.dec_rs2_used = 1'b1;
        bus.dec_rd = 5'd0; bus.dec_rd_w_v = 1'b1;
        #1;
        n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b want 0", bus.stall); end
        step();
        #1;
        n_chk++; if (dut.u_sb.pending !== 32'h0) begin n_fail++; $display("FAIL x0_pending: got %h want 0", dut.u_sb.pending); end
    endtask

    task automatic test_same_cycle();
        step();
        bus.dec_v = 1'b1; bus.dec_rd = 5'd7; bus.dec_rd_w_v = 1'b1;
        step();
        bus.dec_v = 1'b1; bus.dec_rd = 5'd7; bus.dec_rd_w_v = 1'b1;
        bus.wb_v = 1'b1; bus.wb_rd = 5'd7;
        #1;
        n_chk++; if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL same_waw_issue: got %b want 1", bus.issue); end
        step();
        #1;
        n_chk++; if (dut.u_sb.pending !== 32'h0000_0080) begin n_fail++; $display("FAIL same_set_wins: got %h want 00000080", dut.u_sb.pending); end
        step();
        bus.dec_v = 1'b1; bus.dec_rs2 = 5'd7; bus.dec_rs2_used = 1'b1;
        #1;
        n_chk++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL same_read_stall: got %b want 1", bus.stall); end
        step();
        bus.dec_v = 1'b1; bus.dec_rs2 = 5'd7; bus.dec_rs2_used = 1'b1;
        #1;
        n_chk++; if (bus.stall_cnt !== 32'd3) begin n_fail++; $display("FAIL same_cnt3: got %0d want 3", bus.stall_cnt); end
        step();
        bus.dec_v = 1'b1; bus.dec_rs2 = 5'd7; bus.dec_rs2_used = 1'b1;
        bus.wb_v = 1'b1; bus.wb_rd = 5'd7;
        #1;
        n_chk++; if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL same_second_wb: got %b want 1", bus.issue); end
        step();
        #1;
        n_chk++; if (dut.u_sb.pending !== 32'h0) begin n_fail++; $display("FAIL same_drain: got %h want 0", dut.u_sb.pending); end
        n_chk++; if (bus.stall_cnt !== 32'd4) begin n_fail++; $display("FAIL same_cnt4: got %0d want 4", bus.stall_cnt); end
    endtask

    task automatic test_taken_branch();
        step();
        bus.dec_v = 1'b1; bus.dec_br_v = 1'b1;
        #1;
        n_chk++; if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL br_issue: got %b want 1", bus.issue); end
        step();
        bus.dec_v = 1'b1;
        #1;
        n_chk++; if (bus.issue !== 1'b0 || bus.stall !== 1'b1) begin n_fail++; $display("FAIL br_wait_hold: got issue=%b stall=%b want issue=0 stall=1", bus.issue, bus.stall); end
        step();
        bus.dec_v = 1'b1; bus.br_resolve_v = 1'b1; bus.br_taken = 1'b1;
        #1;
        n_chk++; if (bus.flush !== 1'b0 || bus.stall !== 1'b1) begin n_fail++; $display("FAIL br_resolve_cycle: got flush=%b stall=%b want flush=0 stall=1", bus.flush, bus.stall); end
        step();
        bus.dec_v = 1'b1;
        #1;
        n_chk++; if (bus.flush !== 1'b1 || bus.stall !== 1'b0 || bus.issue !== 1'b0) begin n_fail++; $display("FAIL br_flush1: got flush=%b stall=%b issue=%b want 1 0 0", bus.flush, bus.stall, bus.issue); end
        step();
        bus.dec_v = 1'b1;
        #1;
        n_chk++; if (bus.flush !== 1'b1 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL br_flush2: got flush=%b stall=%b want 1 0", bus.flush, bus.stall); end
        step();
        bus.dec_v = 1'b1;
        #1;
        n_chk++; if (bus.flush !== 1'b0 || bus.issue !== 1'b1) begin n_fail++; $display("FAIL br_resume: got flush=%b issue=%b want 0 1", bus.flush, bus.issue); end
        n_chk++; if (bus.stall_cnt !== 32'd6) begin n_fail++; $display("FAIL br_cnt6: got %0d want 6", bus.stall_cnt); end
    endtask

    task automatic test_not_taken();
        step();
        bus.dec_v = 1'b1; bus.dec_br_v = 1'b1;
        step();
        bus.br_resolve_v = 1'b1; bus.br_taken = 1'b0;
        #1;
        n_chk++; if (bus.issue !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL nt_wait_idle: got issue=%b stall=%b want 0 0", bus.issue, bus.stall); end
        step();
        bus.dec_v = 1'b1;
        #1;
        n_chk++; if (bus.flush !== 1'b0 || bus.issue !== 1'b1) begin n_fail++; $display("FAIL nt_resume: got flush=%b issue=%b want 0 1", bus.flush, bus.issue); end
        step();
        bus.br_resolve_v = 1'b1; bus.br_taken = 1'b1;
        step();
        bus.dec_v = 1'b1;
        #1;
        n_chk++; if (bus.flush !== 1'b0 || bus.issue !== 1'b1) begin n_fail++; $display("FAIL nt_run_resolve_ignored: got flush=%b issue=%b want 0 1", bus.flush, bus.issue); end
    endtask

    task automatic test_dcache();
        step();
        bus.dec_v = 1'b1; bus.dcache_busy = 1'b1;
        #1;
        n_chk++; if (bus.stall !== 1'b1 || bus.issue !== 1'b0) begin n_fail++; $display("FAIL dc_stall: got stall=%b issue=%b want 1 0", bus.stall, bus.issue); end
        step();
        bus.dec_v = 1'b1;
        #1;
        n_chk++; if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL dc_release: got %b want 1", bus.issue); end
        n_chk++; if (bus.stall_cnt !== 32'd7) begin n_fail++; $display("FAIL dc_cnt7: got %0d want 7", bus.stall_cnt); end
    endtask

    task automatic test_reset_in_flush();
        step();
        bus.dec_v = 1'b1; bus.dec_rd = 5'd9; bus.dec_rd_w_v = 1'b1;
        step();
        bus.dec_v = 1'b1; bus.dec_br_v = 1'b1;
        step();
        bus.br_resolve_v = 1'b1; bus.br_taken = 1'b1;
        step();
        #1;
        n_chk++; if (bus.flush !== 1'b1 || dut.u_sb.pending !== 32'h0000_0200) begin n_fail++; $display("FAIL rf_pre: got flush=%b pending=%h want 1 00000200", bus.flush, dut.u_sb.pending); end
        #1;
        rst = 1'b1;
        #1;
        n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL rf_flush: got %b want 0", bus.flush); end
        n_chk++; if (dut.u_sb.pending !== 32'h0) begin n_fail++; $display("FAIL rf_pending: got %h want 0", dut.u_sb.pending); end
        n_chk++; if (bus.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rf_cnt: got %0d want 0", bus.stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
        bus.dec_v = 1'b1;
        #1;
        n_chk++; if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL rf_run_after: got %b want 1", bus.issue); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_raw();
        test_x0();
        test_same_cycle();
        test_taken_branch();
        test_not_taken();
        test_dcache();
        test_reset_in_flush();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
